imm_extend_pipe: RTL and testbench

//  Parametrised, pipelined immediate extender for the MIPS datapath; successor to the combinational sign extender.

---
 rtl/imm_extend_pipe_if.sv | 24 ++
 rtl/imm_extend_pipe.sv | 113 +++++++++++
 tb/tb_imm_extend_pipe.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/imm_extend_pipe_if.sv
// Decode-to-execute immediate handshake bundle: valid/ready on the input and output sides.
// master drives immediates and out_ready; slave is the extender's view.
interface imm_extend_pipe_if #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32
);
   logic                 in_valid;
   logic                 in_ready;
   logic [IN_WIDTH-1:0]  in_data;
   logic [1:0]           in_mode;
   logic                 out_valid;
   logic                 out_ready;
   logic [OUT_WIDTH-1:0] out_data;

   modport master (
      output in_valid, in_data, in_mode, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, in_mode, out_ready,
      output in_ready, out_valid, out_data
   );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (sign/zero/upper/branch), 1-cycle latency, valid/ready on both sides.
// IMM_EXT_SKID_EN adds a skid register so in_ready is registered; otherwise in_ready = !out_valid | out_ready.
module imm_extend_pipe #(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 32
) (
   input logic              clk,
   input logic              reset,
   imm_extend_pipe_if.slave bus
);

   localparam logic [1:0] MODE_SEXT   = 2'b00;
   localparam logic [1:0] MODE_ZEXT   = 2'b01;
   localparam logic [1:0] MODE_UPPER  = 2'b10;
   localparam logic [1:0] MODE_BRANCH = 2'b11;
   localparam int         EXT_W       = OUT_WIDTH - IN_WIDTH;

   generate
      if (IN_WIDTH < 2 || OUT_WIDTH < IN_WIDTH + 2) begin : g_bad_params
         $error("imm_extend_pipe: need IN_WIDTH >= 2 and OUT_WIDTH >= IN_WIDTH+2");
      end
   endgenerate

   logic [OUT_WIDTH-1:0] sext_w;
   logic [OUT_WIDTH-1:0] ext_w;
   logic                 in_ready_w;
   logic                 accept;

   logic                 out_valid_q, out_valid_d;
   logic [OUT_WIDTH-1:0] out_data_q,  out_data_d;

   always_comb begin
      sext_w = {{EXT_W{bus.in_data[IN_WIDTH-1]}}, bus.in_data};
      ext_w  = sext_w;
      case (bus.in_mode)
         MODE_SEXT:   ext_w = sext_w;
         MODE_ZEXT:   ext_w = {{EXT_W{1'b0}}, bus.in_data};
         MODE_UPPER:  ext_w = {bus.in_data, {EXT_W{1'b0}}};
         MODE_BRANCH: ext_w = sext_w << 2;
         default:     ext_w = sext_w;
      endcase
   end

`ifdef IMM_EXT_SKID_EN
   logic                 skid_valid_q, skid_valid_d;
   logic [OUT_WIDTH-1:0] skid_data_q,  skid_data_d;

   // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
   assign in_ready_w = ~skid_valid_q;
   assign accept     = bus.in_valid & in_ready_w;

   always_comb begin
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      skid_valid_d = skid_valid_q;
      skid_data_d  = skid_data_q;
      if (!out_valid_q || bus.out_ready) begin
         if (skid_valid_q) begin
            out_valid_d  = 1'b1;
            out_data_d   = skid_data_q;
            skid_valid_d = 1'b0;
         end else if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = ext_w;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_valid_d = 1'b1;
         skid_data_d  = ext_w;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         skid_valid_q <= 1'b0;
         skid_data_q  <= '0;
      end else begin
         skid_valid_q <= skid_valid_d;
         skid_data_q  <= skid_data_d;
      end
   end
`else
   assign in_ready_w = ~out_valid_q | bus.out_ready;
   assign accept     = bus.in_valid & in_ready_w;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = ext_w;
      end else if (bus.out_ready) begin
         out_valid_d = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
      end
   end

   assign bus.in_ready  = in_ready_w;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: 16->32 instance for modes, streaming, stall and reset; 8->16 for the width sweep.
module tb_imm_extend_pipe;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;

   imm_extend_pipe_if #(.IN_WIDTH(16), .OUT_WIDTH(32)) a_if ();
   imm_extend_pipe_if #(.IN_WIDTH(8),  .OUT_WIDTH(16)) b_if ();

   imm_extend_pipe #(.IN_WIDTH(16), .OUT_WIDTH(32)) u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (a_if)
   );

   imm_extend_pipe #(.IN_WIDTH(8), .OUT_WIDTH(16)) u_dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic send_a(input string tag, input logic [1:0] mode, input logic [15:0] data,
                         input logic [31:0] exp);
      a_if.in_valid  = 1'b1;
      a_if.in_mode   = mode;
      a_if.in_data   = data;
      a_if.out_ready = 1'b1;
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      a_if.in_mode  = ~mode;
      #1;
      check({tag, "_vld"}, {31'd0, a_if.out_valid}, 32'd1);
      check(tag, a_if.out_data, exp);
   endtask

   task automatic send_b(input string tag, input logic [1:0] mode, input logic [7:0] data,
                         input logic [15:0] exp);
      b_if.in_valid  = 1'b1;
      b_if.in_mode   = mode;
      b_if.in_data   = data;
      b_if.out_ready = 1'b1;
      @(posedge clk); #1;
      b_if.in_valid = 1'b0;
      check({tag, "_vld"}, {31'd0, b_if.out_valid}, 32'd1);
      check(tag, {16'd0, b_if.out_data}, {16'd0, exp});
   endtask

   logic [1:0]  st_mode [8] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b11, 2'b10, 2'b01};
   logic [15:0] st_data [8] = '{16'h0001, 16'hFFFF, 16'hABCD, 16'h0001,
                                16'hFFFE, 16'h8000, 16'h0001, 16'h1234};
   logic [31:0] st_exp  [8] = '{32'h0000_0001, 32'h0000_FFFF, 32'hABCD_0000, 32'h0000_0004,
                                32'hFFFF_FFFE, 32'hFFFE_0000, 32'h0001_0000, 32'h0000_1234};

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.in_mode = 2'b00; a_if.out_ready = 1'b1;
      b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_mode = 2'b00; b_if.out_ready = 1'b1;

      #2;
      check("rst_vld",  {31'd0, a_if.out_valid}, 32'd0);
      check("rst_data", a_if.out_data, 32'd0);
      @(posedge clk); #3;
      reset = 1'b0;
      @(posedge clk); #1;
      check("rst_rdy",  {31'd0, a_if.in_ready}, 32'd1);
      check("rst_vld2", {31'd0, a_if.out_valid}, 32'd0);

      // Single-word modes, with latency checked around the first one.
      check("pre_vld", {31'd0, a_if.out_valid}, 32'd0);
      send_a("sext", 2'b00, 16'h8000, 32'hFFFF_8000);
      @(posedge clk); #1;
      check("sext_drain", {31'd0, a_if.out_valid}, 32'd0);
      check("sext_keep",  a_if.out_data, 32'hFFFF_8000);
      send_a("zext",   2'b01, 16'h8000, 32'h0000_8000);
      send_a("upper",  2'b10, 16'h1234, 32'h1234_0000);
      send_a("branch", 2'b11, 16'hFFFF, 32'hFFFF_FFFC);
      send_a("sext_pos", 2'b00, 16'h7FFF, 32'h0000_7FFF);
      @(posedge clk); #1;

      // Back-to-back stream at full rate.
      a_if.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_if.in_valid = 1'b1;
         a_if.in_mode  = st_mode[i];
         a_if.in_data  = st_data[i];
         #1;
         check($sformatf("stream%0d_rdy", i), {31'd0, a_if.in_ready}, 32'd1);
         @(posedge clk); #1;
         check($sformatf("stream%0d_vld", i), {31'd0, a_if.out_valid}, 32'd1);
         check($sformatf("stream%0d", i), a_if.out_data, st_exp[i]);
      end
      a_if.in_valid = 1'b0;
      @(posedge clk); #1;
      check("stream_end_vld", {31'd0, a_if.out_valid}, 32'd0);

      // Backpressure: three stalled edges while offering two SEXT words.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.in_mode   = 2'b00;
      a_if.in_data   = 16'h0001;
      #1;
      check("bp_rdy0", {31'd0, a_if.in_ready}, 32'd1);
      @(posedge clk); #1;
      check("bp_vld1",  {31'd0, a_if.out_valid}, 32'd1);
      check("bp_data1", a_if.out_data, 32'h0000_0001);
      a_if.in_data = 16'h0002;
      #1;
`ifdef IMM_EXT_SKID_EN
      check("bp_rdy1", {31'd0, a_if.in_ready}, 32'd1);
`else
      check("bp_rdy1", {31'd0, a_if.in_ready}, 32'd0);
`endif
      @(posedge clk); #1;
`ifdef IMM_EXT_SKID_EN
      a_if.in_valid = 1'b0;
`endif
      #1;
      check("bp_rdy2",  {31'd0, a_if.in_ready}, 32'd0);
      check("bp_vld2",  {31'd0, a_if.out_valid}, 32'd1);
      check("bp_data2", a_if.out_data, 32'h0000_0001);
      @(posedge clk); #1;
      check("bp_rdy3",  {31'd0, a_if.in_ready}, 32'd0);
      check("bp_vld3",  {31'd0, a_if.out_valid}, 32'd1);
      check("bp_data3", a_if.out_data, 32'h0000_0001);
      a_if.out_ready = 1'b1;
      #1;
`ifndef IMM_EXT_SKID_EN
      check("bp_rdy_rel", {31'd0, a_if.in_ready}, 32'd1);
`endif
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      check("bp_vld_w2",  {31'd0, a_if.out_valid}, 32'd1);
      check("bp_data_w2", a_if.out_data, 32'h0000_0002);
      @(posedge clk); #1;
      check("bp_drain", {31'd0, a_if.out_valid}, 32'd0);

      // Reset asserted while a result is held under stall.
      a_if.out_ready = 1'b0;
      a_if.in_valid  = 1'b1;
      a_if.in_mode   = 2'b00;
      a_if.in_data   = 16'h5555;
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      check("rs_held", a_if.out_data, 32'h0000_5555);
      #2;
      reset = 1'b1;
      #1;
      check("rs_vld",  {31'd0, a_if.out_valid}, 32'd0);
      check("rs_data", a_if.out_data, 32'd0);
      @(posedge clk); #3;
      reset = 1'b0;
      a_if.out_ready = 1'b1;
      a_if.in_valid  = 1'b1;
      a_if.in_mode   = 2'b01;
      a_if.in_data   = 16'h00AA;
      @(posedge clk); #1;
      a_if.in_valid = 1'b0;
      check("rs_post_vld",  {31'd0, a_if.out_valid}, 32'd1);
      check("rs_post_data", a_if.out_data, 32'h0000_00AA);

      // 8->16 width sweep.
      send_b("w8_sext",   2'b00, 8'h80, 16'hFF80);
      send_b("w8_branch", 2'b11, 8'h7F, 16'h01FC);
      send_b("w8_upper",  2'b10, 8'h12, 16'h1200);
      send_b("w8_zext",   2'b01, 8'h80, 16'h0080);
      @(posedge clk); #1;
      check("w8_drain", {31'd0, b_if.out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
